// File: rtl/ls_arbiter.sv
// Local-store arbiter: odd-pipe quadword accesses vs. instruction-fetch line bursts.
// Optional performance counters are built when LS_ARB_PERF_EN is defined.
module ls_arbiter #(
  parameter int FETCH_BEATS  = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             ls_req_i,
  input  logic             ls_wr_i,
  input  logic [14:0]      ls_addr_i,
  input  logic [127:0]     ls_wdata_i,
  output logic             ls_gnt_o,
  output logic             ls_rvalid_o,
  output logic [127:0]     ls_rdata_o,
  input  logic             if_req_i,
  input  logic [14:0]      if_addr_i,
  output logic             if_rvalid_o,
  output logic [2:0]       if_beat_o,
  output logic [127:0]     if_rdata_o,
  output logic             if_done_o,
  output logic             mem_en_o,
  output logic             mem_wr_en_o,
  output logic [14:0]      mem_addr_o,
  output logic [127:0]     mem_wdata_o,
  input  logic [127:0]     mem_rdata_i,
  output logic [CNT_W-1:0] perf_ls_cnt_o,
  output logic [CNT_W-1:0] perf_if_cnt_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  localparam logic [14:0] QW_MASK   = 15'h7FF0;
  localparam int          SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [2:0]  LAST_BEAT = 3'(FETCH_BEATS - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e         state_q, state_d;
  logic [2:0]     beat_cnt_q, beat_cnt_d;
  logic [14:0]    fetch_base_q, fetch_base_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           rd_pending_q, rd_pending_d;
  logic           rd_owner_q, rd_owner_d;
  logic [2:0]     rd_beat_q, rd_beat_d;

  logic           ls_issue;
  logic           if_issue;
  logic [2:0]     issue_beat;
  logic [14:0]    issue_addr;
  logic           out_en;
  logic           squash;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      fetch_base_q <= '0;
      starve_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_beat_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      fetch_base_q <= fetch_base_d;
      starve_q     <= starve_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      rd_beat_q    <= rd_beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    fetch_base_d = fetch_base_q;
    starve_d     = starve_q;
    ls_issue     = 1'b0;
    if_issue     = 1'b0;
    issue_beat   = '0;
    issue_addr   = '0;

    case (state_q)
      IDLE: begin
        if (if_req_i && !flush_i && (!ls_req_i || starve_q == STARVE_MAX)) begin
          if_issue     = 1'b1;
          issue_addr   = if_addr_i & QW_MASK;
          fetch_base_d = if_addr_i & QW_MASK;
          beat_cnt_d   = 3'd1;
          starve_d     = '0;
          state_d      = FETCH;
        end else begin
          ls_issue = ls_req_i;
          if (!if_req_i) begin
            starve_d = '0;
          end else if (ls_req_i && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end

      FETCH: begin
        // A flush abandons the rest of the burst; the data side is not held off.
        if (flush_i) begin
          beat_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          if_issue   = 1'b1;
          issue_beat = beat_cnt_q;
          issue_addr = fetch_base_q + 15'({beat_cnt_q, 4'b0000});
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign out_en      = !reset_i;
  assign ls_gnt_o    = out_en && ls_issue;
  assign mem_en_o    = out_en && (ls_issue || if_issue);
  assign mem_wr_en_o = out_en && ls_issue && ls_wr_i;
  assign mem_addr_o  = !out_en ? '0 :
                       ls_issue ? (ls_addr_i & QW_MASK) : issue_addr;
  assign mem_wdata_o = (out_en && ls_issue && ls_wr_i) ? ls_wdata_i : '0;

  always_comb begin
    rd_pending_d = ls_issue ? !ls_wr_i : if_issue;
    rd_owner_d   = if_issue;
    rd_beat_d    = issue_beat;
  end

  assign squash      = flush_i && (state_q == FETCH);
  assign ls_rvalid_o = rd_pending_q && !rd_owner_q;
  assign if_rvalid_o = rd_pending_q && rd_owner_q && !squash;
  assign if_beat_o   = rd_beat_q;
  assign if_done_o   = if_rvalid_o && (rd_beat_q == LAST_BEAT);
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;

`ifdef LS_ARB_PERF_EN
  logic [CNT_W-1:0] perf_ls_q, perf_if_q, perf_stall_q;
  logic             stall;

  assign stall = (ls_req_i && !ls_issue) || (if_req_i && !if_issue);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_ls_q    <= '0;
      perf_if_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (ls_issue) perf_ls_q    <= perf_ls_q + CNT_W'(1);
      if (if_issue) perf_if_q    <= perf_if_q + CNT_W'(1);
      if (stall)    perf_stall_q <= perf_stall_q + CNT_W'(1);
    end
  end

  assign perf_ls_cnt_o    = perf_ls_q;
  assign perf_if_cnt_o    = perf_if_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  assign perf_ls_cnt_o    = '0;
  assign perf_if_cnt_o    = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed bench for ls_arbiter: expected read returns are queued at issue time
// and checked when due; combinational issue outputs are checked every cycle.
module tb_ls_arbiter;
  localparam int FB    = 4;
  localparam int CNT_W = 32;

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic             flush_i;
  logic             ls_req_i;
  logic             ls_wr_i;
  logic [14:0]      ls_addr_i;
  logic [127:0]     ls_wdata_i;
  logic             ls_gnt_o;
  logic             ls_rvalid_o;
  logic [127:0]     ls_rdata_o;
  logic             if_req_i;
  logic [14:0]      if_addr_i;
  logic             if_rvalid_o;
  logic [2:0]       if_beat_o;
  logic [127:0]     if_rdata_o;
  logic             if_done_o;
  logic             mem_en_o;
  logic             mem_wr_en_o;
  logic [14:0]      mem_addr_o;
  logic [127:0]     mem_wdata_o;
  logic [127:0]     mem_rdata_i;
  logic [CNT_W-1:0] perf_ls_cnt_o, perf_if_cnt_o, perf_stall_cnt_o;

  ls_arbiter #(.FETCH_BEATS(FB), .STARVE_LIMIT(8), .CNT_W(CNT_W)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
    .ls_req_i(ls_req_i), .ls_wr_i(ls_wr_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rvalid_o(if_rvalid_o),
    .if_beat_o(if_beat_o), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .mem_en_o(mem_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .perf_ls_cnt_o(perf_ls_cnt_o), .perf_if_cnt_o(perf_if_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [127:0] pat(logic [14:0] a);
    return {16{8'hA5}} ^ {113'b0, a};
  endfunction

  // Memory: read data appears one cycle after a read strobe.
  always @(posedge clock_i)
    mem_rdata_i <= (mem_en_o && !mem_wr_en_o) ? pat(mem_addr_o) : 128'h0;

  typedef struct {
    int           due;
    logic         owner;
    logic [2:0]   beat;
    logic [127:0] data;
    logic         vis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_issue(string tag, bit gnt, bit en, bit wr, logic [14:0] addr,
                           bit owner, logic [2:0] beat, bit vis);
    exp_t e;
    chk({tag, ".ls_gnt"}, ls_gnt_o, gnt);
    chk({tag, ".mem_en"}, mem_en_o, en);
    if (en) begin
      chk({tag, ".mem_wr_en"}, mem_wr_en_o, wr);
      chk({tag, ".mem_addr"}, mem_addr_o, addr);
      if (wr) chk({tag, ".mem_wdata"}, mem_wdata_o, ls_wdata_i);
      else begin
        e = '{cyc + 1, owner, beat, pat(addr), vis};
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_returns(string tag);
    exp_t         e;
    bit           lv = 0, iv = 0;
    logic [2:0]   b = '0;
    logic [127:0] d = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.vis) begin
        lv = !e.owner;
        iv = e.owner;
        b  = e.beat;
        d  = e.data;
      end
    end
    chk({tag, ".ls_rvalid"}, ls_rvalid_o, lv);
    chk({tag, ".if_rvalid"}, if_rvalid_o, iv);
    chk({tag, ".if_done"}, if_done_o, iv && (b == 3'(FB - 1)));
    if (lv) chk({tag, ".ls_rdata"}, ls_rdata_o, d);
    if (iv) begin
      chk({tag, ".if_rdata"}, if_rdata_o, d);
      chk({tag, ".if_beat"}, if_beat_o, b);
    end
  endtask

  task automatic cycle_chk(string tag, bit gnt, bit en, bit wr, logic [14:0] addr,
                           bit owner, logic [2:0] beat, bit vis);
    #1;
    exp_issue(tag, gnt, en, wr, addr, owner, beat, vis);
    check_returns(tag);
    @(posedge clock_i);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".ls_gnt"}, ls_gnt_o, 0);
    chk({tag, ".mem_en"}, mem_en_o, 0);
    chk({tag, ".mem_wr_en"}, mem_wr_en_o, 0);
    chk({tag, ".mem_addr"}, mem_addr_o, 0);
    chk({tag, ".mem_wdata"}, mem_wdata_o, 0);
    chk({tag, ".ls_rvalid"}, ls_rvalid_o, 0);
    chk({tag, ".if_rvalid"}, if_rvalid_o, 0);
    chk({tag, ".if_done"}, if_done_o, 0);
    chk({tag, ".if_beat"}, if_beat_o, 0);
    chk({tag, ".ls_rdata"}, ls_rdata_o, 0);
    chk({tag, ".if_rdata"}, if_rdata_o, 0);
    chk({tag, ".perf_ls"}, perf_ls_cnt_o, 0);
    chk({tag, ".perf_if"}, perf_if_cnt_o, 0);
    chk({tag, ".perf_stall"}, perf_stall_cnt_o, 0);
  endtask

  task automatic do_reset();
    reset_i  = 1'b1;
    ls_req_i = 1'b0;
    if_req_i = 1'b0;
    flush_i  = 1'b0;
    #1;
    chk_all_zero("in_reset");
    sb.delete();
    @(posedge clock_i);
    #1;
    cyc++;
    reset_i = 1'b0;
    #1;
    chk_all_zero("after_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] a;
    reset_i = 1'b1; flush_i = 1'b0; ls_req_i = 1'b0; ls_wr_i = 1'b0;
    ls_addr_i = '0; ls_wdata_i = '0; if_req_i = 1'b0; if_addr_i = '0;
    repeat (2) @(posedge clock_i);
    #1;
    do_reset();

    // Load at 0x0123: quadword aligned, data one cycle later.
    ls_req_i = 1'b1; ls_wr_i = 1'b0; ls_addr_i = 15'h0123;
    cycle_chk("load", 1, 1, 0, 15'h0120, 0, 0, 1);
    ls_req_i = 1'b0;
    cycle_chk("load_ret", 0, 0, 0, 0, 0, 0, 0);

    // Store: no read return.
    ls_req_i = 1'b1; ls_wr_i = 1'b1; ls_addr_i = 15'h0455;
    ls_wdata_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    cycle_chk("store", 1, 1, 1, 15'h0450, 0, 0, 0);
    ls_req_i = 1'b0; ls_wr_i = 1'b0;
    cycle_chk("store_ret", 0, 0, 0, 0, 0, 0, 0);

    // Burst wrapping at the top of the local store.
    if_req_i = 1'b1; if_addr_i = 15'h7FE0;
    for (int k = 0; k < FB; k++) begin
      a = 15'h7FE0 + 15'(16 * k);
      cycle_chk("wrap_burst", 0, 1, 0, a, 1, 3'(k), 1);
    end
    if_req_i = 1'b0;
    cycle_chk("wrap_done", 0, 0, 0, 0, 0, 0, 0);

    // Starvation bound: 8 data grants, then the burst takes over.
    ls_req_i = 1'b1; ls_addr_i = 15'h0200; if_req_i = 1'b1; if_addr_i = 15'h1008;
    for (int k = 0; k < 8; k++) cycle_chk("starve_ls", 1, 1, 0, 15'h0200, 0, 0, 1);
    for (int k = 0; k < FB; k++) begin
      a = 15'h1000 + 15'(16 * k);
      cycle_chk("starve_if", 0, 1, 0, a, 1, 3'(k), 1);
    end
    if_req_i = 1'b0;
    cycle_chk("starve_resume", 1, 1, 0, 15'h0200, 0, 0, 1);
    ls_req_i = 1'b0;
    cycle_chk("starve_idle", 0, 0, 0, 0, 0, 0, 0);

    // Flush the cycle after beat 1: beat 1 squashed, waiting load granted next.
    if_req_i = 1'b1; if_addr_i = 15'h2000;
    cycle_chk("fl_b0", 0, 1, 0, 15'h2000, 1, 0, 1);
    ls_req_i = 1'b1; ls_addr_i = 15'h0300;
    cycle_chk("fl_b1", 0, 1, 0, 15'h2010, 1, 1, 0);
    flush_i = 1'b1;
    cycle_chk("fl_cyc", 0, 0, 0, 0, 0, 0, 0);
    flush_i = 1'b0; if_req_i = 1'b0;
    cycle_chk("fl_ls", 1, 1, 0, 15'h0300, 0, 0, 1);
    ls_req_i = 1'b0;
    cycle_chk("fl_idle", 0, 0, 0, 0, 0, 0, 0);

    // Reset after beat 2 is issued: its return is discarded.
    if_req_i = 1'b1; if_addr_i = 15'h3000;
    cycle_chk("rst_b0", 0, 1, 0, 15'h3000, 1, 0, 1);
    cycle_chk("rst_b1", 0, 1, 0, 15'h3010, 1, 1, 1);
    cycle_chk("rst_b2", 0, 1, 0, 15'h3020, 1, 2, 0);
    do_reset();
    ls_req_i = 1'b1; ls_addr_i = 15'h0040;
    cycle_chk("rst_ls", 1, 1, 0, 15'h0040, 0, 0, 1);
    ls_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 15'h0100;
    for (int k = 0; k < FB; k++) begin
      a = 15'h0100 + 15'(16 * k);
      cycle_chk("rst_burst", 0, 1, 0, a, 1, 3'(k), 1);
    end
    if_req_i = 1'b0;
    cycle_chk("rst_burst_done", 0, 0, 0, 0, 0, 0, 0);

    // Uncontended traffic for the performance counters.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      ls_req_i = 1'b1; ls_addr_i = 15'(16 * k);
      cycle_chk("perf_ld", 1, 1, 0, 15'(16 * k), 0, 0, 1);
    end
    ls_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 15'h0500;
    for (int k = 0; k < FB; k++) begin
      a = 15'h0500 + 15'(16 * k);
      cycle_chk("perf_burst", 0, 1, 0, a, 1, 3'(k), 1);
    end
    if_req_i = 1'b0;
    cycle_chk("perf_done", 0, 0, 0, 0, 0, 0, 0);
`ifdef LS_ARB_PERF_EN
    chk("perf_ls_cnt", perf_ls_cnt_o, 3);
    chk("perf_if_cnt", perf_if_cnt_o, 4);
    chk("perf_stall_cnt", perf_stall_cnt_o, 0);
`else
    chk("perf_ls_cnt", perf_ls_cnt_o, 0);
    chk("perf_if_cnt", perf_if_cnt_o, 0);
    chk("perf_stall_cnt", perf_stall_cnt_o, 0);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ls_arbiter.md
Name: ls_arbiter

Overview:
Arbitrates the single-port 128-bit local store between two requesters: the odd pipe (quadword load/store) and instruction fetch (multi-quadword line bursts). The block sits between odd_pipe/fetch and the local store SRAM. It sequences fetch bursts beat by beat and routes read data back to the requester that issued each read. It honours the odd-pipe branch flush and bounds fetch starvation with a counter.

Parameters:
FETCH_BEATS, 4, quadwords per fetch burst (power of 2, 2..8)
STARVE_LIMIT, 8, consecutive lost arbitrations after which fetch wins over data
CNT_W, 32, width of the performance counters (optional feature)

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high
flush  in  1  branch flush from the odd pipe
ls_req  in  1  odd-pipe access request; held until ls_gnt
ls_wr  in  1  1 = store, 0 = load
ls_addr  in  15  byte address [0:14]
ls_wdata  in  128  store data
ls_gnt  out  1  combinational; access issued to memory this cycle
ls_rvalid  out  1  load data valid
ls_rdata  out  128  load data
if_req  in  1  fetch burst request; held until if_done or flush
if_addr  in  15  burst base byte address
if_rvalid  out  1  fetch beat data valid
if_beat  out  3  beat index of if_rdata
if_rdata  out  128  fetch beat data
if_done  out  1  with last beat's if_rvalid
mem_en  out  1  memory access strobe
mem_wr_en  out  1  memory write enable
mem_addr  out  15  memory address, low 4 bits always 0
mem_wdata  out  128  memory write data
mem_rdata  in  128  read data, valid 1 cycle after read strobe
perf_ls_cnt, perf_if_cnt, perf_stall_cnt  out  CNT_W each  performance counters

Behaviour:
- All addresses to memory are masked with 0x7FF0 (quadword aligned).
- Fetch beat k address = (if_addr & 0x7FF0) + 16*k, modulo 2^15 (wraps at top of local store).
- States: IDLE, FETCH.
- IDLE: fetch wins iff if_req && !flush && (!ls_req || starve_cnt == STARVE_LIMIT). A fetch win issues beat 0, sets beat_cnt = 1 and moves to FETCH. Otherwise, if ls_req, the data access is issued and ls_gnt = 1.
- FETCH: issues one beat per cycle. ls_gnt = 0. After beat FETCH_BEATS-1 is issued the state returns to IDLE.
- Flush in FETCH: no beat is issued that cycle and the state goes to IDLE. Any fetch read outstanding from the previous cycle is squashed: if_rvalid = 0 and if_done = 0. Data accesses are unaffected by flush.
- starve_cnt increments, saturating at STARVE_LIMIT, each IDLE cycle in which if_req is high and data was granted. It clears when a burst starts or when if_req is low.
- Read return: a registered tag {rd_pending, rd_owner} is captured on every read strobe.
  - ls_rvalid = rd_pending && owner == DATA.
  - if_rvalid = rd_pending && owner == FETCH && !squashed.
  - ls_rdata and if_rdata are both driven from mem_rdata.
  - if_beat is registered with the tag. if_done = if_rvalid && if_beat == FETCH_BEATS-1.
- Stores produce no rvalid.
- Load-to-data latency is 1 cycle after ls_gnt. A full burst takes FETCH_BEATS issue cycles, with if_done FETCH_BEATS cycles after the first beat.
- Data waits at most FETCH_BEATS cycles while a burst is in progress. Fetch waits at most STARVE_LIMIT+1 cycles.
- if_req dropped mid-burst is illegal; the burst completes regardless.
- Reset (asynchronous, mid-operation allowed):
  - State goes to IDLE; beat_cnt, starve_cnt, rd_pending and the counters clear.
  - Every output is 0; memory outputs are 0.
  - An in-flight read is discarded.

Optional Feature:
LS_ARB_PERF_EN:
- Defined: perf_ls_cnt counts data grants, perf_if_cnt counts fetch beats issued, and perf_stall_cnt counts cycles with a request pending but not granted (ls or if, counted once per cycle). All three wrap at 2^CNT_W and clear on reset.
- Undefined: the counter registers are absent and the three ports are tied to 0.

Test Plan:
- Reset mid-burst (beat 2 issued) -> next cycle all outputs 0, no if_rvalid, state IDLE.
- ls_req load at 0x0123, mem returns 0xA5.. -> mem_addr 0x0120 with ls_gnt the same cycle; ls_rvalid and ls_rdata = 0xA5.. one cycle later.
- if_req at 0x7FE0, FETCH_BEATS=4 -> mem_addr sequence 0x7FE0, 0x7FF0, 0x0000, 0x0010; if_beat 0..3; if_done on beat 3.
- ls_req held high continuously with if_req raised -> data granted 8 cycles, fetch burst starts on cycle 9, ls_gnt low for 4 cycles.
- flush on the cycle after beat 1 is issued -> beat 1 data suppressed, no if_done, returns to IDLE; a pending ls_req is granted the following cycle.
- LS_ARB_PERF_EN defined: 3 loads plus one 4-beat burst with no contention -> perf_ls_cnt=3, perf_if_cnt=4, perf_stall_cnt=0.
